// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq
//   Sequential BCD-to-binary converter (reverse double-dabble). The BCD digits
//   are loaded above an all-zero binary field; on each clock the whole work
//   register shifts right by one. Any BCD nibble that reads 8 or more after the
//   shift then has 3 subtracted from it. After output_lenght shifts, the low
//   field holds the binary value. Whatever remains in the BCD field is the part
//   of the value that does not fit in output_lenght bits.
//
// Parameters
//   output_lenght  width of binary_out; also the number of shift cycles
//   nDisplays      number of BCD digits (digit 0 = units)
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low; clears all state
//   start       conversion request, sampled only while idle
//   bcd_in      BCD digits, captured on the edge that accepts start
//   busy        high while shifting
//   done        one-cycle pulse when binary_out/overflow/error update
//   binary_out  result, held until the next completion
//   overflow    value exceeded output_lenght bits (result truncated)
//   error       invalid digit seen (only with BCD_CHECK_EN, else tied 0)
//
// Build option
//   BCD_CHECK_EN  reject conversions with any digit > 9. Such a conversion
//                 completes immediately with error=1 and leaves binary_out
//                 unchanged.

module bcd_to_bin_seq #(
  parameter int unsigned output_lenght = 10,
  parameter int unsigned nDisplays     = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [nDisplays-1:0][3:0]     bcd_in,
  output logic                          busy,
  output logic                          done,
  output logic [output_lenght-1:0]      binary_out,
  output logic                          overflow,
  output logic                          error
);

  localparam int unsigned BCD_W  = nDisplays * 4;
  localparam int unsigned WORK_W = BCD_W + output_lenght;
  localparam int unsigned CNT_W  = $clog2(output_lenght + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t              state;
  logic [WORK_W-1:0]   work;
  logic [WORK_W-1:0]   work_next;
  logic [CNT_W-1:0]    cnt;
  logic                last_shift;
  logic                bcd_bad;

  // One reverse double-dabble step: shift right, then correct each BCD nibble.
  always_comb begin
    work_next = work >> 1;
    for (int unsigned i = 0; i < nDisplays; i++) begin
      if (work_next[output_lenght + 4*i +: 4] >= 4'd8)
        work_next[output_lenght + 4*i +: 4] = work_next[output_lenght + 4*i +: 4] - 4'd3;
    end
  end

  assign last_shift = (cnt == CNT_W'(output_lenght - 1));

`ifdef BCD_CHECK_EN
  always_comb begin
    bcd_bad = 1'b0;
    for (int unsigned i = 0; i < nDisplays; i++) begin
      if (bcd_in[i] > 4'd9)
        bcd_bad = 1'b1;
    end
  end

  // A rejected start sets error; the next valid completion clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      error <= 1'b0;
    else if (state == IDLE && start && bcd_bad)
      error <= 1'b1;
    else if (state == SHIFT && last_shift)
      error <= 1'b0;
  end
`else
  assign bcd_bad = 1'b0;
  assign error   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      work       <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      binary_out <= '0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (bcd_bad) begin
              // Rejected: complete right away without touching binary_out.
              done     <= 1'b1;
              overflow <= 1'b0;
            end else begin
              work  <= {bcd_in, {output_lenght{1'b0}}};
              cnt   <= '0;
              busy  <= 1'b1;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work <= work_next;
          cnt  <= cnt + CNT_W'(1);
          if (last_shift) begin
            binary_out <= work_next[output_lenght-1:0];
            overflow   <= |work_next[WORK_W-1:output_lenght];
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
